// File: rtl/id_free_list_allocator.sv
// id_free_list_allocator
// Circular free list of DEPTH tags. After reset it fills itself with IDs
// 0..DEPTH-1, then hands out one ID per cycle from the head and takes back up
// to NUM_RELEASE_PORTS IDs per cycle at the tail. It also drives the toggle
// ports of an external in-use tracker: port 0 marks allocations, ports
// 1..NUM_RELEASE_PORTS mark accepted releases.
// The release inputs are named i_release/i_release_id because "release" is a
// reserved word in SystemVerilog.
module id_free_list_allocator #(
  parameter int DEPTH             = 64,
  parameter int NUM_RELEASE_PORTS = 2,
  localparam int AW               = $clog2(DEPTH)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  output logic                                  o_init_done,
  output logic                                  o_alloc_valid,
  output logic [AW-1:0]                         o_alloc_id,
  input  logic                                  i_alloc_pop,
  input  logic [NUM_RELEASE_PORTS-1:0]          i_release,
  input  logic [NUM_RELEASE_PORTS-1:0][AW-1:0]  i_release_id,
  output logic [NUM_RELEASE_PORTS:0]            o_toggle,
  output logic [NUM_RELEASE_PORTS:0][AW-1:0]    o_toggle_addr,
  output logic                                  o_overflow_err
);

  localparam int CW = AW + 1;
  localparam int NP = NUM_RELEASE_PORTS;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [AW-1:0]        r_mem [DEPTH];
  logic [AW-1:0]        r_rd_ptr;
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_init_ptr;
  logic [CW-1:0]        r_count;
  logic                 r_overflow;

  logic                 w_run;
  logic                 w_pop;
  logic [CW-1:0]        w_free;
  logic [CW-1:0]        w_n_req;
  logic [CW-1:0]        w_n_acc;
  logic [NP-1:0]        w_accept;
  logic [NP-1:0][AW-1:0] w_wr_addr;
  logic                 w_overflow;

  // Head of the list is read combinationally; a released ID only becomes
  // visible here after it has been written at a clock edge (no bypass).
  assign o_alloc_id     = r_mem[r_rd_ptr];
  assign o_overflow_err = r_overflow;
  assign w_run          = (r_state == ST_RUN);

  // FSM next state and status outputs: INIT ends once the last ID is written.
  always_comb begin
    w_state_next  = r_state;
    o_init_done   = 1'b0;
    o_alloc_valid = 1'b0;
    case (r_state)
      ST_INIT: begin
        if (r_init_ptr == AW'(DEPTH - 1)) begin
          w_state_next = ST_RUN;
        end else begin
          w_state_next = ST_INIT;
        end
      end
      ST_RUN: begin
        w_state_next  = ST_RUN;
        o_init_done   = 1'b1;
        o_alloc_valid = (r_count != {CW{1'b0}});
      end
      default: begin
        w_state_next = ST_INIT;
      end
    endcase
  end

  // Pop qualification, release acceptance (drop highest ports first when the
  // list cannot hold them all) and the tracker toggle strobes.
  always_comb begin
    w_pop     = i_alloc_pop & o_alloc_valid;
    // A pop in the same cycle frees one slot before releases are placed.
    w_free    = CW'(DEPTH) - r_count + {{AW{1'b0}}, w_pop};
    w_n_req   = {CW{1'b0}};
    w_n_acc   = {CW{1'b0}};
    w_accept  = {NP{1'b0}};
    w_wr_addr = '0;
    for (int p = 0; p < NP; p++) begin
      w_wr_addr[p] = r_wr_ptr + w_n_acc[AW-1:0];
      if (w_run && i_release[p]) begin
        w_n_req = w_n_req + CW'(1);
        if (w_n_acc < w_free) begin
          w_accept[p] = 1'b1;
          w_n_acc     = w_n_acc + CW'(1);
        end else begin
          w_accept[p] = 1'b0;
        end
      end else begin
        w_accept[p] = 1'b0;
      end
    end
    w_overflow = (w_n_req > w_free);

    o_toggle         = '0;
    o_toggle_addr    = '0;
    o_toggle[0]      = w_pop;
    o_toggle_addr[0] = o_alloc_id;
    for (int p = 0; p < NP; p++) begin
      o_toggle[p+1]      = w_accept[p];
      o_toggle_addr[p+1] = i_release_id[p];
    end
  end

  // State register, pointers, occupancy count and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_INIT;
      r_rd_ptr   <= {AW{1'b0}};
      r_wr_ptr   <= {AW{1'b0}};
      r_init_ptr <= {AW{1'b0}};
      r_count    <= {CW{1'b0}};
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (!w_run) begin
        r_init_ptr <= r_init_ptr + AW'(1);
        r_count    <= r_count + CW'(1);
        // Tail wraps back to slot 0 once every slot holds an ID.
        r_wr_ptr   <= {AW{1'b0}};
      end else begin
        r_rd_ptr <= r_rd_ptr + {{(AW-1){1'b0}}, w_pop};
        r_wr_ptr <= r_wr_ptr + w_n_acc[AW-1:0];
        r_count  <= r_count + w_n_acc - {{AW{1'b0}}, w_pop};
        if (w_overflow) begin
          r_overflow <= 1'b1;
        end else begin
          r_overflow <= r_overflow;
        end
      end
    end
  end

  // ID storage (not reset): sequential fill during INIT, tail writes in RUN.
  always_ff @(posedge clk) begin
    if (!w_run) begin
      r_mem[r_init_ptr] <= r_init_ptr;
    end else begin
      for (int p = 0; p < NP; p++) begin
        if (w_accept[p]) begin
          r_mem[w_wr_addr[p]] <= i_release_id[p];
        end
      end
    end
  end

endmodule

// File: doc/id_free_list_allocator.md
Name: id_free_list_allocator

Overview:
- Allocates and reclaims tags (instruction/register IDs) from a pool of DEPTH IDs, using a multi-write-port circular free list.
- Drives the toggle-port side of a toggle-based in-use tracker:
  - toggle port 0 flips an ID to in-use when it is allocated;
  - toggle ports 1..NUM_RELEASE_PORTS flip it back when it is released.
- Fills itself with every ID after reset, then serves one allocation per cycle and accepts up to NUM_RELEASE_PORTS releases per cycle.

Parameters:
DEPTH, 64, number of IDs; must be a power of two, at least 4
NUM_RELEASE_PORTS, 2, number of independent release ports

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
init_done  output  1  high once the free list holds all DEPTH IDs after reset
alloc_valid  output  1  a free ID is available at alloc_id
alloc_id  output  $clog2(DEPTH)  head of the free list
alloc_pop  input  1  consume alloc_id this cycle; ignored when alloc_valid=0
release  input  1 [NUM_RELEASE_PORTS]  return an ID to the pool
release_id  input  $clog2(DEPTH) [NUM_RELEASE_PORTS]  ID being returned
toggle  output  1 [NUM_RELEASE_PORTS+1]  toggle strobes to the in-use tracker
toggle_addr  output  $clog2(DEPTH) [NUM_RELEASE_PORTS+1]  toggle addresses
overflow_err  output  1  sticky: a release was attempted while the list was full

Behaviour:
- State: DEPTH-entry ID storage, rd_ptr and wr_ptr ($clog2(DEPTH) bits, wrapping naturally), count ($clog2(DEPTH)+1 bits), init_ptr, and a two-state FSM {INIT, RUN}.
- Reset (asynchronous, rst_n=0): FSM=INIT, rd_ptr=wr_ptr=count=init_ptr=0, overflow_err=0.
  - Outputs while in reset: init_done=0, alloc_valid=0, all toggle=0.
  - Storage contents are not reset.
- INIT state:
  - Each cycle writes storage[init_ptr]=init_ptr, then increments init_ptr and count.
  - When init_ptr==DEPTH-1 is written, the FSM moves to RUN and wr_ptr=0 (wrapped).
  - INIT lasts exactly DEPTH cycles after rst_n rises.
  - During INIT, alloc_valid=0 and the release inputs are ignored (no toggles issued).
- RUN state:
  - init_done=1.
  - alloc_valid = (count!=0); alloc_id = storage[rd_ptr], combinational read.
  - Pop: pop = alloc_pop & alloc_valid. A pop increments rd_ptr.
  - Releases:
    - k = popcount(release).
    - Active ports are written in ascending port order to storage[wr_ptr + prefix_index].
    - wr_ptr += k.
  - count_next = count + k - pop.
  - Simultaneous pop and release: both take effect. A released ID is never bypassed to alloc_id in the same cycle.
    - Empty list + release of ID 7: alloc_valid=0 this cycle, 1 next cycle with alloc_id=7.
  - Full list: if count + k - pop > DEPTH, overflow_err sets (sticky until reset).
    - Releases that do not fit are dropped, highest port index first; pointers and count never exceed DEPTH.
    - A pop in the same cycle frees one slot first.
  - Duplicate or never-allocated release IDs are not detected (caller responsibility). They do not corrupt pointer/count arithmetic.
- Toggle outputs: combinational, zero latency.
  - toggle[0] = pop, toggle_addr[0] = alloc_id.
  - toggle[1+k] = release[k] & FSM==RUN & not dropped; toggle_addr[1+k] = release_id[k].
- Reset mid-operation (any state): returns immediately to INIT and refills from ID 0. All outstanding allocations are forgotten; the in-use tracker must be cleared by its own init path.
- Latency:
  - Allocation: ID is visible the same cycle it is at the head; the pop takes effect at the next edge.
  - Release: the ID can be allocated at the earliest on the next cycle, if the list was empty.

Test Plan:
- Init: release rst_n, hold alloc_pop=0 -> init_done=0 and alloc_valid=0 for 64 cycles; then init_done=1, alloc_valid=1, alloc_id=0, toggle all 0.
- Drain: alloc_pop=1 for 64 cycles -> alloc_id sequence 0..63, toggle[0]=1 with toggle_addr[0] matching each cycle; then alloc_valid=0, and a further pop produces no toggle.
- Dual release on empty: release={1,1}, release_id={5,9} -> toggle[1]=1 addr 5, toggle[2]=1 addr 9 that cycle; next cycle alloc_id=5, after a pop alloc_id=9.
- Steady-state wrap: pop and release 1 ID every cycle for 200 cycles -> count constant, FIFO order preserved across pointer wrap, no overflow_err.
- Overflow: with the list full, release={1,0}, id=3 -> overflow_err=1 sticky, toggle[1]=0, count stays 64; same stimulus plus alloc_pop=1 -> accepted, no error.
- Reset mid-INIT and mid-RUN: assert rst_n=0 asynchronously -> outputs clear without a clock edge; refill restarts from ID 0 and takes 64 cycles.
